// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types: word/register-index widths and the
// architecturally special register indices.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [DATA_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA   = 5'd31;

endpackage : mips_pkg

// File: rtl/mips_regfile_rd_port.sv
// One register-file read port: forces $zero to 0 and, when enabled, forwards a
// same-cycle committing write ahead of the stored array word.
module regfile_rd_port #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [DATA_W-1:0] arr_word,
  output logic [DATA_W-1:0] rdata
);

  logic fwd_hit;

  // A write under reset never commits, so it must not be forwarded either.
  assign fwd_hit = BYPASS && !reset && we && (waddr != '0) && (waddr == raddr);

  // NOTE: rdata gets a default before any branch so this block can never infer a latch.
  always_comb begin
    rdata = arr_word;
    if (raddr == '0) begin
      rdata = '0;
    end else if (fwd_hit) begin
      rdata = wdata;
    end
  end

endmodule : regfile_rd_port

// File: rtl/mips_regfile.sv
// 32x32 MIPS general-purpose register file: one synchronous write port, two
// combinational read ports, $zero hardwired, optional write-first bypass.
module mips_regfile #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::REG_ADDR_W,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  localparam int DEPTH = 1 << ADDR_W;

  // Index 0 has no storage; $zero is produced by the read ports.
  logic [DATA_W-1:0] regs_q [1:DEPTH-1];
  logic [DATA_W-1:0] regs_d [1:DEPTH-1];
  logic [DATA_W-1:0] arr_word1;
  logic [DATA_W-1:0] arr_word2;

  always_comb begin
    regs_d = regs_q;
    for (int i = 1; i < DEPTH; i++) begin
      if (reset) begin
        regs_d[i] = '0;
      end else if (we && (waddr == ADDR_W'(i))) begin
        regs_d[i] = wdata;
      end
    end
  end

  // NOTE: the array is cleared through regs_d under the synchronous reset, so the
  // flop process is a plain register with non-blocking updates and no reset branch.
  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  always_comb begin
    arr_word1 = '0;
    arr_word2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (raddr1 == ADDR_W'(i)) arr_word1 = regs_q[i];
      if (raddr2 == ADDR_W'(i)) arr_word2 = regs_q[i];
    end
  end

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port1 (
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr1),
    .arr_word (arr_word1),
    .rdata    (rdata1)
  );

  regfile_rd_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_rd_port2 (
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr    (raddr2),
    .arr_word (arr_word2),
    .rdata    (rdata2)
  );

endmodule : mips_regfile

// File: tb/tb_mips_regfile.sv
// Scoreboard bench for mips_regfile: a bypassing and a non-bypassing instance
// share stimulus and are checked against an array-based reference model.
module tb_mips_regfile;
  import mips_pkg::*;

  logic     clk;
  logic     reset;
  logic     we;
  reg_idx_t waddr;
  word_t    wdata;
  reg_idx_t raddr1;
  reg_idx_t raddr2;
  word_t    rdata1_b, rdata2_b;
  word_t    rdata1_n, rdata2_n;

  mips_regfile #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W), .BYPASS(1'b1)) u_dut_byp (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1_b), .raddr2(raddr2), .rdata2(rdata2_b)
  );

  mips_regfile #(.DATA_W(DATA_W), .ADDR_W(REG_ADDR_W), .BYPASS(1'b0)) u_dut_nob (
    .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1_n), .raddr2(raddr2), .rdata2(rdata2_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    word_t e1_byp;
    word_t e2_byp;
    word_t e1_nob;
    word_t e2_nob;
  } exp_t;

  exp_t  sb_q[$];
  word_t model_mem [32];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check(input string name, input word_t act, input word_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Reference read: what a MIPS register read returns this cycle.
  function automatic word_t model_rd(input reg_idx_t a, input bit byp);
    if (a == REG_ZERO) return '0;
    if (byp && !reset && we && waddr != REG_ZERO && waddr == a) return wdata;
    return model_mem[a];
  endfunction

  // Drive one cycle (called just after a rising edge), post expectations, then commit.
  task automatic cycle(input string tag, input logic rst, input logic w, input reg_idx_t wa,
                       input word_t wd, input reg_idx_t ra1, input reg_idx_t ra2,
                       input bit expect_it = 1'b1);
    exp_t e;
    reset  = rst;
    we     = w;
    waddr  = wa;
    wdata  = wd;
    raddr1 = ra1;
    raddr2 = ra2;
    if (expect_it) begin
      e.tag    = tag;
      e.e1_byp = model_rd(ra1, 1'b1);
      e.e2_byp = model_rd(ra2, 1'b1);
      e.e1_nob = model_rd(ra1, 1'b0);
      e.e2_nob = model_rd(ra2, 1'b0);
      sb_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model_mem[i] = '0;
    end else if (w && wa != REG_ZERO) begin
      model_mem[wa] = wd;
    end
    #1;
  endtask

  // Monitor: combinational outputs are settled mid-cycle.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check({e.tag, " byp.rdata1"}, rdata1_b, e.e1_byp);
      check({e.tag, " byp.rdata2"}, rdata2_b, e.e2_byp);
      check({e.tag, " nob.rdata1"}, rdata1_n, e.e1_nob);
      check({e.tag, " nob.rdata2"}, rdata2_n, e.e2_nob);
    end
  end

  initial begin
    reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr1 = '0; raddr2 = '0;
    for (int i = 0; i < 32; i++) model_mem[i] = 'x;
    @(posedge clk);
    #1;

    // Outputs are undefined before the first reset edge, so this cycle is unchecked.
    cycle("reset", 1'b1, 1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd0, 1'b0);
    for (int a = 0; a < 32; a++)
      cycle("sweep", 1'b0, 1'b0, 5'd0, 32'h0, reg_idx_t'(a), reg_idx_t'(31 - a));

    cycle("wr5", 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    cycle("rd5", 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6);

    cycle("wr0", 1'b0, 1'b1, REG_ZERO, 32'hFFFFFFFF, 5'd0, 5'd0);
    cycle("rd0", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    cycle("byp31", 1'b0, 1'b1, REG_RA, 32'h12345678, REG_RA, REG_RA);
    cycle("rd31", 1'b0, 1'b0, 5'd0, 32'h0, REG_RA, REG_RA);

    cycle("wr7", 1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd1, 5'd2);
    cycle("rst_wr7", 1'b1, 1'b1, 5'd7, 32'h11111111, 5'd7, 5'd7);
    cycle("rd7", 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

    cycle("b2b1", 1'b0, 1'b1, 5'd3, 32'h1, 5'd0, 5'd3);
    cycle("b2b2", 1'b0, 1'b1, 5'd3, 32'h2, 5'd0, 5'd3);
    cycle("b2b3", 1'b0, 1'b1, 5'd3, 32'h3, 5'd0, 5'd3);
    cycle("b2b4", 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd3);

    // Random traffic; reads are biased toward the write address to hit the bypass.
    for (int n = 0; n < 400; n++) begin
      logic     r, w;
      reg_idx_t wa, a1, a2;
      word_t    wd;
      r  = ($urandom_range(0, 49) == 0);
      w  = ($urandom_range(0, 3) != 0);
      wa = reg_idx_t'($urandom_range(0, 31));
      wd = $urandom;
      a1 = ($urandom_range(0, 2) == 0) ? wa : reg_idx_t'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? wa : reg_idx_t'($urandom_range(0, 31));
      cycle("rand", r, w, wa, wd, a1, a2);
    end

    we = 1'b0;
    for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(posedge clk);
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mips_regfile
